aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES-128 encryption sequencer built around one shared, pipelined SubBytes unit.
//  - Accepts a plaintext block and performs the initial AddRoundKey.
//  - Runs 10 rounds: it drives the SubBytes unit, then applies ShiftRows/MixColumns/AddRoundKey itself.
//  - Returns the ciphertext over a valid/ready handshake.
//  - Sits between the block I/O wrapper and the SubBytes/key-schedule datapath.
// PARAMETERS
//  SB_LATENCY  2   clk edges from sb_in change to matching sb_out (S regs + output regs); legal 1..7
//  NR          10  number of rounds (fixed for AES-128; not user-overridable)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    plaintext offered
//  in_ready   out  1    controller can accept (high only in IDLE)
//  in_data    in   128  plaintext; byte k (FIPS order) at [8k+7:8k]
//  rk_round   out  4    index of round key requested; combinational read
//  round_key  in   128  round key rk_round, valid same cycle; same byte order
//  sb_in      out  128  state to SubBytes unit (= state register)
//  sb_out     in   128  SubBytes result, SB_LATENCY cycles after sb_in
//  out_valid  out  1    ciphertext valid; held until accepted
//  out_ready  in   1    sink accepts
//  out_data   out  128  ciphertext (= state register)
//  busy       out  1    high in every state except IDLE
// BEHAVIOUR
//  - Byte k maps to row k%4, column k/4 (column-major, FIPS-197).
//  - FSM states: IDLE, SUB, RND, DONE. Reset: IDLE, state=0, round=0, wait_cnt=0, out_valid=0, in_ready=1.
//  - IDLE: rk_round=0. When in_valid&&in_ready: state<=in_data^round_key, round<=1, wait_cnt<=0, go SUB.
//  - SUB: state register frozen, so sb_in is stable. wait_cnt increments each cycle. When wait_cnt==SB_LATENCY-1, go RND.
//  - RND: rk_round=round.
//    - round<NR: state<=MixColumns(ShiftRows(sb_out))^round_key.
//    - round==NR: state<=ShiftRows(sb_out)^round_key (no MixColumns).
//    - round<NR: round++, wait_cnt<=0, go SUB. round==NR: go DONE.
//  - DONE: out_valid=1, out_data stable. When out_ready: go IDLE.
//    - in_ready stays 0 in DONE: no same-cycle bypass, so there is one idle cycle between blocks.
//  - Latency: out_valid rises 10*(SB_LATENCY+1) cycles after the accept edge (30 for default).
//    Throughput is one block per >=32 cycles.
//  - rk_round in SUB/DONE is don't-care. Drive round to keep it quiet.
//  - in_valid while busy: ignored and not stored. Source must hold it.
//  - GF arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). All widths exact, no carry out.
//  - rst asserted mid-operation: immediate return to reset values. The partial block is lost and out_valid drops combinationally with the state reg.
// CONFIGURATION
//  AES_ROUND_CTRL_ABORT_EN defined:
//  - Adds input port abort (1 bit).
//  - abort high at an edge in SUB or RND: go IDLE, round<=0, no output produced.
//  - abort in IDLE: ignored.
//  - abort in DONE with out_ready high: handshake completes normally.
//  - abort in DONE with out_ready low: block discarded, go IDLE.
//  AES_ROUND_CTRL_ABORT_EN undefined: no abort port; every accepted block runs to DONE.
// STRUCTURE
//  - aes_ctrl_pkg:
//    - state enum {IDLE,SUB,RND,DONE}
//    - localparam NR=10 and round-counter width 4
//    - functions xtime, shift_rows(128), mix_columns(128)
//  - Sub-module aes_shift_mix (combinational): in 128, last_round 1 -> out 128.
//    ShiftRows, with MixColumns bypassed when last_round=1.
//  - SubBytes unit is external; the top level connects sb_in/sb_out to it.
// TESTING
//  1. FIPS-197 C.1 vectors:
//     - key 000102..0f, pt 00112233445566778899aabbccddeeff, bench supplies round keys.
//     - Required: out_data = 69c4e0d86a7b0430d8cdb78070b4c55a (FIPS byte order), out_valid exactly 30 cycles after accept.
//  2. Back-pressure:
//     - Hold out_ready=0 for 20 cycles after out_valid.
//     - Required: out_data and out_valid stable, in_ready=0.
//     - Then out_ready=1 -> IDLE next edge.
//     - Second block accepted one cycle after that edge.
//  3. Busy input: in_valid held high with a different pt during a run -> not captured. Captured only once in_ready=1.
//  4. Reset at cycle 12 of a run:
//     - Required: busy=0, out_valid=0, in_ready=1 immediately.
//     - The next block encrypts correctly (FIPS vector again).
//  5. SB_LATENCY=1 and 7 builds: FIPS vector correct; latency 20 and 80 cycles respectively.
//  6. With AES_ROUND_CTRL_ABORT_EN:
//     - Pulse abort in round 5 -> IDLE next edge, out_valid never asserted.
//     - Next block correct.
//     - Abort in DONE with out_ready=1 -> single normal transfer.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg
//   Shared types, constants and GF(2^8) helpers for the iterative AES-128
//   round controller.
//   Byte k of a 128-bit block sits at [8k+7:8k] and maps to row k%4,
//   column k/4 (column-major, FIPS-197 order).
package aes_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SUB, RND, DONE} state_e;

  localparam int NR      = 10;
  localparam int ROUND_W = 4;
  // Wide enough for a SubBytes latency of up to 7 cycles.
  localparam int WAIT_W  = 3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(row+4*c) +: 8] = s[8*(row+4*((c+row)%4)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      // 3*x is expressed as xtime(x)^x.
      r[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_shift_mix.sv
// aes_shift_mix
//   Combinational ShiftRows followed by MixColumns; MixColumns is bypassed
//   in the final round.
// Ports:
//   in_data    in  128  SubBytes output for the current round
//   last_round in  1    1 = final round (ShiftRows only)
//   out_data   out 128  transformed state, before AddRoundKey
module aes_shift_mix
  import aes_ctrl_pkg::*;
(
  input  logic [127:0] in_data,
  input  logic         last_round,
  output logic [127:0] out_data
);

  logic [127:0] shifted;

  assign shifted  = shift_rows(in_data);
  assign out_data = last_round ? shifted : mix_columns(shifted);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Iterative AES-128 encryption sequencer around one shared, pipelined
//   external SubBytes unit. Performs the initial AddRoundKey on accept, then
//   10 rounds of SubBytes (external) + ShiftRows/MixColumns/AddRoundKey,
//   and presents the ciphertext on a valid/ready handshake.
// Configuration macro:
//   AES_ROUND_CTRL_ABORT_EN - adds the abort input, which discards an
//   in-flight block (SUB/RND) or an unaccepted result (DONE, out_ready low).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      plaintext input handshake
//   rk_round/round_key             round-key request (combinational read)
//   sb_in/sb_out                   to/from the SubBytes unit
//   out_valid/out_ready/out_data   ciphertext output handshake
//   abort                          (AES_ROUND_CTRL_ABORT_EN only)
//   busy                           high whenever not IDLE
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int SB_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic [ROUND_W-1:0] rk_round,
  input  logic [127:0]       round_key,
  output logic [127:0]       sb_in,
  input  logic [127:0]       sb_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy
);

  state_e              state_q, state_d;
  logic [127:0]        st_q, st_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [127:0]        sm_out;
  logic                abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  aes_shift_mix u_shift_mix (
    .in_data    (sb_out),
    .last_round (round_q == ROUND_W'(NR)),
    .out_data   (sm_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      round_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      round_q    <= round_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    round_d    = round_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d       = in_data ^ round_key;
          round_d    = ROUND_W'(1);
          wait_cnt_d = '0;
          state_d    = SUB;
        end
      end
      SUB: begin
        // State register is frozen so sb_in stays stable while the
        // SubBytes pipeline fills.
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_W'(SB_LATENCY - 1)) state_d = RND;
      end
      RND: begin
        st_d = sm_out ^ round_key;
        if (round_q == ROUND_W'(NR)) begin
          state_d = DONE;
        end else begin
          round_d    = round_q + 1'b1;
          wait_cnt_d = '0;
          state_d    = SUB;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over normal sequencing, except that an output handshake
    // already completing in DONE is honoured.
    if (abort_hit && (state_q == SUB || state_q == RND)) begin
      st_d       = st_q;
      round_d    = '0;
      wait_cnt_d = '0;
      state_d    = IDLE;
    end else if (abort_hit && state_q == DONE && !out_ready) begin
      state_d = IDLE;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sb_in     = st_q;
  assign out_data  = st_q;
  // Outside IDLE the round counter is presented even where it is unused,
  // so the key-store address only moves once per round.
  assign rk_round  = (state_q == IDLE) ? '0 : round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
  parameter int SB_LATENCY = 2;
  localparam int LAT = 10 * (SB_LATENCY + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_round;
  logic [127:0] round_key;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         abort;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  logic [7:0]   sbox [0:255];
  logic [127:0] rk_cur [0:10];
  logic [127:0] sb_pipe [SB_LATENCY];

  always #5 clk = ~clk;

  aes_round_ctrl #(.SB_LATENCY(SB_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_round(rk_round), .round_key(round_key),
    .sb_in(sb_in), .sb_out(sb_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  // ---------------- reference arithmetic ----------------
  // Polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox[x[8*k +: 8]];
    return r;
  endfunction

  // Reverse from hex-literal (byte 0 leftmost) to port layout (byte 0 at LSB).
  function automatic logic [127:0] fips(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*(15-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] round_key_of(input logic [127:0] key, input int n);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox[t[8*j +: 8]];
        t[7:0] ^= rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n+3], w[4*n+2], w[4*n+1], w[4*n]};
  endfunction

  // Textbook cipher on a [row][col] grid.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   g [4][4];
    logic [7:0]   h [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] k;
    logic [127:0] r;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    k = round_key_of(key, 0);
    for (int c = 0; c < 4; c++) for (int rw = 0; rw < 4; rw++)
      g[rw][c] = pt[8*(rw+4*c) +: 8] ^ k[8*(rw+4*c) +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++) for (int rw = 0; rw < 4; rw++)
        h[rw][c] = sbox[g[(rw)][(c+rw)%4]];
      for (int c = 0; c < 4; c++) for (int rw = 0; rw < 4; rw++) begin
        if (rnd < 10) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-rw+4)%4], h[j][c]);
          g[rw][c] = acc;
        end else begin
          g[rw][c] = h[rw][c];
        end
      end
      k = round_key_of(key, rnd);
      for (int c = 0; c < 4; c++) for (int rw = 0; rw < 4; rw++)
        g[rw][c] ^= k[8*(rw+4*c) +: 8];
    end
    for (int c = 0; c < 4; c++) for (int rw = 0; rw < 4; rw++) r[8*(rw+4*c) +: 8] = g[rw][c];
    return r;
  endfunction

  // ---------------- environment models ----------------
  always @(posedge clk) begin
    sb_pipe[0] <= sub_bytes(sb_in);
    for (int i = 1; i < SB_LATENCY; i++) sb_pipe[i] <= sb_pipe[i-1];
  end
  assign sb_out = sb_pipe[SB_LATENCY-1];

  always_comb begin
    round_key = '0;
    if (int'(rk_round) <= 10) round_key = rk_cur[rk_round];
  end

  always @(posedge clk) if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    for (int i = 0; i <= 10; i++) rk_cur[i] = round_key_of(key, i);
  endtask

  // Called just after a negedge; returns just after the accept edge.
  task automatic accept(input logic [127:0] pt, input string tag);
    int n;
    in_data  = pt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "_ready"}, in_ready, 1);
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 2000) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, lat, LAT);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input string tag);
    int lat;
    load_key(key);
    out_ready = 1'b1;
    accept(pt, tag);
    in_valid = 1'b0;
    wait_out(tag, lat);
    check({tag, "_ct"}, out_data, encrypt(pt, key));
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] fk, fpt, fct, pa, pb, key;
    int lat, x0, hold;
    logic saw;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; abort = 1'b0;
    build_sbox();
    fk  = fips(128'h000102030405060708090a0b0c0d0e0f);
    fpt = fips(128'h00112233445566778899aabbccddeeff);
    fct = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    load_key(fk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rk_round", rk_round, 0);
    check("rst_state", out_data, 0);

    // FIPS-197 C.1 with back-pressure
    out_ready = 1'b0;
    accept(fpt, "fips");
    in_valid = 1'b0;
    wait_out("fips", lat);
    check("fips_ct", out_data, fct);
    check("model_fips", encrypt(fpt, fk), fct);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, fct);
      check("bp_in_ready", in_ready, 0);
    end
    x0 = xfer_cnt;
    pb = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_data = pb; in_valid = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    check("bp_xfer", xfer_cnt, x0 + 1);
    @(negedge clk);
    check("bp2_busy", busy, 1);
    in_valid = 1'b0;
    wait_out("bp2", lat);
    check("bp2_ct", out_data, encrypt(pb, fk));
    @(negedge clk);

    // in_valid held with other data while busy
    key = {$urandom, $urandom, $urandom, $urandom};
    pa  = {$urandom, $urandom, $urandom, $urandom};
    pb  = {$urandom, $urandom, $urandom, $urandom};
    load_key(key);
    out_ready = 1'b0;
    accept(pa, "busyA");
    in_data = pb;
    wait_out("busyA", lat);
    check("busyA_ct", out_data, encrypt(pa, key));
    out_ready = 1'b1;
    @(negedge clk);
    check("busyB_ready", in_ready, 1);
    @(negedge clk);
    check("busyB_busy", busy, 1);
    in_valid = 1'b0;
    wait_out("busyB", lat);
    check("busyB_ct", out_data, encrypt(pb, key));
    @(negedge clk);

    // reset mid-run
    load_key(fk);
    accept(fpt, "rstrun");
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block(fpt, fk, "post_rst");

    // random blocks with random back-pressure
    for (int b = 0; b < 6; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pa  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(pa, "rnd");
      in_valid = 1'b0;
      wait_out("rnd", lat);
      hold = $urandom_range(0, 5);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("rnd_hold", out_valid, 1);
      end
      check("rnd_ct", out_data, encrypt(pa, key));
      out_ready = 1'b1;
      @(negedge clk);
      check("rnd_drain", out_valid, 0);
    end

`ifdef AES_ROUND_CTRL_ABORT_EN
    // abort during round 5
    load_key(fk);
    out_ready = 1'b1;
    accept(fpt, "abort");
    in_valid = 1'b0;
    repeat (4 * (SB_LATENCY + 1) + 1) @(negedge clk);
    x0 = xfer_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    saw = 1'b0;
    repeat (LAT + 5) begin @(negedge clk); if (out_valid) saw = 1'b1; end
    check("abort_no_out", saw, 0);
    check("abort_no_xfer", xfer_cnt, x0);
    run_block(fpt, fk, "post_abort");

    // abort in DONE with out_ready high: normal transfer
    accept(fpt, "abdone1");
    in_valid = 1'b0;
    wait_out("abdone1", lat);
    check("abdone1_ct", out_data, fct);
    x0 = xfer_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abdone1_xfer", xfer_cnt, x0 + 1);
    check("abdone1_ready", in_ready, 1);

    // abort in DONE with out_ready low: discarded
    out_ready = 1'b0;
    accept(fpt, "abdone0");
    in_valid = 1'b0;
    wait_out("abdone0", lat);
    x0 = xfer_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abdone0_valid", out_valid, 0);
    check("abdone0_ready", in_ready, 1);
    check("abdone0_xfer", xfer_cnt, x0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
